// File: rtl/video_pkg.sv
// Shared types and constants for the SPI-fed video control path.
package video_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STARTUP    = 2'd1,
        WAIT_FIRST = 2'd2,
        PLAY       = 2'd3
    } ctrl_state_t;

    // 200x150 scaled frame in normal use, 8x6 for quick simulation
    localparam int NORMAL_FRAME_BITS      = 30000;
    localparam int TEST_FRAME_BITS        = 48;
    localparam int DEFAULT_STARTUP_FRAMES = 60;

endpackage

// File: rtl/spi_sync.sv
// Brings the asynchronous SPI pins into the pixel clock domain and turns
// synced SCLK rising edges into a one-cycle strobe with its data bit.
module spi_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sclk,
    input  logic spi_mosi,
    input  logic spi_cs_n,
    output logic strobe,
    output logic bit_value,
    output logic cs_active
);

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] cs_n_sync_reg;
    logic                   sclk_prev_reg;
    logic                   strobe_reg;
    logic                   bit_reg;
    logic                   cs_reg;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   cs_n_s;
    logic                   rise;

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
    assign cs_n_s = cs_n_sync_reg[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev_reg;

    // cs is re-registered so it lines up with the strobe it qualifies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            cs_n_sync_reg <= '1;
            sclk_prev_reg <= 1'b0;
            strobe_reg    <= 1'b0;
            bit_reg       <= 1'b0;
            cs_reg        <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi_mosi};
            cs_n_sync_reg <= {cs_n_sync_reg[SYNC_STAGES-2:0], spi_cs_n};
            sclk_prev_reg <= sclk_s;
            strobe_reg    <= rise;
            cs_reg        <= ~cs_n_s;
            if (rise) begin
                bit_reg <= mosi_s;
            end
        end
    end

    assign strobe    = strobe_reg;
    assign bit_value = bit_reg;
    assign cs_active = cs_reg;

endmodule

// File: rtl/frame_stream_ctrl.sv
// Frame bit counting, ping-pong bank schedule and VGA startup sequencing
// for the SPI video stream; banks only swap on a VGA frame boundary.
module frame_stream_ctrl
    import video_pkg::*;
#(
    parameter int FRAME_BITS     = NORMAL_FRAME_BITS,
    parameter int STARTUP_FRAMES = DEFAULT_STARTUP_FRAMES,
    parameter int SYNC_STAGES    = 2
) (
    input  logic CLK_40,
    input  logic reset,
    input  logic spi_sclk,
    input  logic spi_mosi,
    input  logic spi_cs_n,
    input  logic frame_boundary,
    output logic data_clk_rising_edge,
    output logic received_bit,
    output logic chip_select,
    output logic video_data_ready,
    output logic read_bank1,
    output logic read_bank2,
    output logic VGA_en,
    output logic VGA_startup_en,
    output logic frame_overrun
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int SU_W  = $clog2(STARTUP_FRAMES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT     = CNT_W'(FRAME_BITS - 1);
    localparam logic [SU_W-1:0]  LAST_STARTUP = SU_W'(STARTUP_FRAMES - 1);

    ctrl_state_t      state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [SU_W-1:0]  startup_cnt_reg, startup_cnt_next;
    logic             frame_pending_reg, frame_pending_next;
    logic             bank_sel_reg, bank_sel_next;
    logic             overrun_reg, overrun_next;

    logic raw_strobe, raw_bit, cs_sync;
    logic in_window, active, candidate, accept, swap;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_spi_sync (
        .clk       (CLK_40),
        .rst       (reset),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .strobe    (raw_strobe),
        .bit_value (raw_bit),
        .cs_active (cs_sync)
    );

    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            bit_cnt_reg       <= '0;
            startup_cnt_reg   <= '0;
            frame_pending_reg <= 1'b0;
            bank_sel_reg      <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            bit_cnt_reg       <= bit_cnt_next;
            startup_cnt_reg   <= startup_cnt_next;
            frame_pending_reg <= frame_pending_next;
            bank_sel_reg      <= bank_sel_next;
            overrun_reg       <= overrun_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        bit_cnt_next       = bit_cnt_reg;
        startup_cnt_next   = startup_cnt_reg;
        frame_pending_next = frame_pending_reg;
        bank_sel_next      = bank_sel_reg;
        overrun_next       = overrun_reg;

        in_window = (state_reg == WAIT_FIRST) || (state_reg == PLAY);
        active    = (state_reg != IDLE);
        candidate = raw_strobe & cs_sync & in_window;
        accept    = candidate & ~frame_pending_reg;
        swap      = frame_boundary & frame_pending_reg;

        // accept and swap are exclusive: one needs pending low, the other high
        if (accept) begin
            if (bit_cnt_reg == LAST_BIT) begin
                bit_cnt_next       = '0;
                frame_pending_next = 1'b1;
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end
        if (candidate & frame_pending_reg) begin
            overrun_next = 1'b1;
        end
        if (swap) begin
            bank_sel_next      = ~bank_sel_reg;
            frame_pending_next = 1'b0;
        end

        case (state_reg)
            IDLE: state_next = STARTUP;
            STARTUP: begin
                if (frame_boundary) begin
                    startup_cnt_next = startup_cnt_reg + 1'b1;
                    if (startup_cnt_reg == LAST_STARTUP) begin
                        state_next = WAIT_FIRST;
                    end
                end
            end
            WAIT_FIRST: begin
                if (swap) begin
                    state_next = PLAY;
                end
            end
            PLAY:    state_next = PLAY;
            default: state_next = IDLE;
        endcase

        data_clk_rising_edge = accept;
        received_bit         = accept & raw_bit;
        chip_select          = cs_sync & active;
        video_data_ready     = cs_sync & in_window;
        read_bank1           = active & ~bank_sel_reg;
        read_bank2           = active & bank_sel_reg;
        VGA_en               = active;
        VGA_startup_en       = (state_reg == STARTUP) || (state_reg == WAIT_FIRST);
        frame_overrun        = overrun_reg;
    end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Randomized SPI/boundary stimulus against a cycle-level behavioural model
// of the frame controller, plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_frame_stream_ctrl;
    import video_pkg::*;

    localparam int FB = TEST_FRAME_BITS;
    localparam int SF = 60;
    localparam int SS = 2;
    localparam int D  = SS + 1;

    logic CLK_40         = 1'b0;
    logic reset          = 1'b1;
    logic spi_sclk       = 1'b0;
    logic spi_mosi       = 1'b0;
    logic spi_cs_n       = 1'b1;
    logic frame_boundary = 1'b0;
    logic data_clk_rising_edge, received_bit, chip_select, video_data_ready;
    logic read_bank1, read_bank2, VGA_en, VGA_startup_en, frame_overrun;

    frame_stream_ctrl #(
        .FRAME_BITS     (FB),
        .STARTUP_FRAMES (SF),
        .SYNC_STAGES    (SS)
    ) dut (
        .CLK_40               (CLK_40),
        .reset                (reset),
        .spi_sclk             (spi_sclk),
        .spi_mosi             (spi_mosi),
        .spi_cs_n             (spi_cs_n),
        .frame_boundary       (frame_boundary),
        .data_clk_rising_edge (data_clk_rising_edge),
        .received_bit         (received_bit),
        .chip_select          (chip_select),
        .video_data_ready     (video_data_ready),
        .read_bank1           (read_bank1),
        .read_bank2           (read_bank2),
        .VGA_en               (VGA_en),
        .VGA_startup_en       (VGA_startup_en),
        .frame_overrun        (frame_overrun)
    );

    always #12.5 CLK_40 = ~CLK_40;

    int checks = 0;
    int errors = 0;

    // model: mode 0 idle, 1 startup, 2 wait-first, 3 play; bank 1 or 2 displayed
    int   m_mode = 0, m_sc = 0, m_bits = 0, m_pend = 0, m_bank = 1;
    logic m_ovr = 1'b0;
    int   coincide_seen = 0;
    int   strobe_cnt = 0;
    logic sclk_h [0:D+1];
    logic cs_n_h [0:D+1];
    logic mosi_h [0:D+1];
    logic sent_bits [$];
    logic dut_bits [$];

    task automatic check_lit(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    // per-cycle compare: pins reach the control logic D cycles after they change
    initial begin
        logic [7:0] got, expv;
        logic strobe_d, cs_d, bit_d, cand, acc, act, win;
        int old_pend;
        forever begin
            @(negedge CLK_40);
            for (int i = D + 1; i > 0; i--) begin
                sclk_h[i] = sclk_h[i-1];
                cs_n_h[i] = cs_n_h[i-1];
                mosi_h[i] = mosi_h[i-1];
            end
            sclk_h[0] = spi_sclk;
            cs_n_h[0] = spi_cs_n;
            mosi_h[0] = spi_mosi;
            got = {data_clk_rising_edge, chip_select, video_data_ready, read_bank1,
                   read_bank2, VGA_en, VGA_startup_en, frame_overrun};
            if (data_clk_rising_edge) begin
                strobe_cnt++;
                dut_bits.push_back(received_bit);
            end
            if (reset) begin
                for (int i = 0; i <= D + 1; i++) begin
                    sclk_h[i] = 1'b0;
                    cs_n_h[i] = 1'b1;
                    mosi_h[i] = 1'b0;
                end
                m_mode = 0; m_sc = 0; m_bits = 0; m_pend = 0; m_bank = 1; m_ovr = 1'b0;
                checks++;
                if (got !== 8'h00) begin
                    errors++;
                    $display("FAIL reset_outputs got %b expected %b at %0t", got, 8'h00, $time);
                end
            end else begin
                strobe_d = sclk_h[D] & ~sclk_h[D+1];
                cs_d     = ~cs_n_h[D];
                bit_d    = mosi_h[D];
                act      = (m_mode != 0);
                win      = (m_mode >= 2);
                cand     = strobe_d & cs_d & win;
                acc      = cand & (m_pend == 0);
                expv = {acc, cs_d & act, cs_d & win, act & (m_bank == 1), act & (m_bank == 2),
                        act, (m_mode == 1) || (m_mode == 2), m_ovr};
                checks++;
                if (got !== expv) begin
                    errors++;
                    $display("FAIL cycle_outputs got %b expected %b (strobe,cs,ready,rb1,rb2,en,white,ovr) at %0t",
                             got, expv, $time);
                end
                if (acc) begin
                    checks++;
                    if (received_bit !== bit_d) begin
                        errors++;
                        $display("FAIL received_bit got %b expected %b at %0t", received_bit, bit_d, $time);
                    end
                end
                old_pend = m_pend;
                if (acc) begin
                    m_bits++;
                    if (m_bits == FB) begin
                        m_bits = 0;
                        m_pend = 1;
                        if (frame_boundary) coincide_seen = 1;
                    end
                end
                if (cand && old_pend != 0) m_ovr = 1'b1;
                if (frame_boundary && old_pend != 0) begin
                    m_bank = 3 - m_bank;
                    m_pend = 0;
                    if (m_mode == 2) m_mode = 3;
                end
                if (m_mode == 0) begin
                    m_mode = 1;
                end else if (m_mode == 1 && frame_boundary) begin
                    m_sc++;
                    if (m_sc == SF) m_mode = 2;
                end
            end
        end
    end

    task automatic send_bit(input logic b);
        @(posedge CLK_40); #1;
        spi_mosi = b;
        spi_sclk = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge CLK_40);
        #1 spi_sclk = 1'b1;
        sent_bits.push_back(b);
        repeat ($urandom_range(2, 3)) @(posedge CLK_40);
        #1 spi_sclk = 1'b0;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
    endtask

    task automatic cs_low();
        @(posedge CLK_40); #1 spi_cs_n = 1'b0;
        repeat (2) @(posedge CLK_40);
    endtask

    task automatic cs_high();
        repeat (2) @(posedge CLK_40);
        #1 spi_cs_n = 1'b1;
        repeat (D + 3) @(posedge CLK_40);
        #1;
    endtask

    task automatic pulse_boundary();
        @(posedge CLK_40); #1 frame_boundary = 1'b1;
        @(posedge CLK_40); #1 frame_boundary = 1'b0;
    endtask

    task automatic run_startup(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(1, 4)) @(posedge CLK_40);
            pulse_boundary();
        end
    endtask

    task automatic apply_reset();
        @(posedge CLK_40); #1;
        reset = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; frame_boundary = 1'b0;
        #1;
        check_lit("async_reset_outputs",
                  int'({data_clk_rising_edge, chip_select, video_data_ready, read_bank1,
                        read_bank2, VGA_en, VGA_startup_en, frame_overrun}), 0);
        repeat (6) @(posedge CLK_40);
        #1 reset = 1'b0;
    endtask

    task automatic clear_logs(output int base);
        sent_bits.delete();
        dut_bits.delete();
        base = strobe_cnt;
    endtask

    task automatic check_bits(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check_lit($sformatf("%s_bit%0d", tag, i),
                      (i < dut_bits.size()) ? int'(dut_bits[i]) : 2, int'(sent_bits[i]));
        end
    endtask

    initial begin
        int base;
        repeat (6) @(posedge CLK_40);
        #1;
        check_lit("reset_vga_en", int'(VGA_en), 0);
        reset = 1'b0;
        check_lit("idle_cycle_rb1", int'(read_bank1), 0);
        @(posedge CLK_40); #1;
        check_lit("startup_vga_en", int'(VGA_en), 1);
        check_lit("startup_white", int'(VGA_startup_en), 1);
        check_lit("startup_rb1", int'(read_bank1), 1);

        run_startup(SF - 1);
        check_lit("still_startup", int'(dut.state_reg), int'(STARTUP));
        run_startup(1);
        check_lit("state_wait_first", int'(dut.state_reg), int'(WAIT_FIRST));
        check_lit("model_wait_first", m_mode, 2);
        check_lit("wait_white", int'(VGA_startup_en), 1);
        $display("startup: %0d boundaries, now waiting for first frame", SF);

        // one contiguous frame, then swap
        clear_logs(base);
        cs_low(); send_bits(FB); cs_high();
        check_lit("t2_strobes", strobe_cnt - base, FB);
        check_bits("t2", FB);
        check_lit("t2_rb1_before", int'(read_bank1), 1);
        pulse_boundary();
        check_lit("t2_rb2_after", int'(read_bank2), 1);
        check_lit("t2_white_off", int'(VGA_startup_en), 0);
        check_lit("t2_state_play", int'(dut.state_reg), int'(PLAY));
        $display("frame 1: %0d bits contiguous, swapped to bank 2", FB);

        // frame split across two CS bursts
        clear_logs(base);
        cs_low(); send_bits(20); cs_high();
        repeat (100) @(posedge CLK_40);
        #1 check_lit("t3_not_pending", int'(dut.frame_pending_reg), 0);
        cs_low(); send_bits(FB - 20); cs_high();
        check_lit("t3_pending", int'(dut.frame_pending_reg), 1);
        check_lit("t3_strobes", strobe_cnt - base, FB);
        check_bits("t3", FB);
        check_lit("t3_rb2_before", int'(read_bank2), 1);
        pulse_boundary();
        check_lit("t3_rb1_after", int'(read_bank1), 1);
        $display("frame 2: 20+%0d bits over two bursts, swapped to bank 1", FB - 20);

        // overrun: 5 bits beyond a completed frame are dropped
        clear_logs(base);
        cs_low(); send_bits(FB + 5); cs_high();
        check_lit("t4_strobes", strobe_cnt - base, FB);
        check_bits("t4", FB);
        check_lit("t4_overrun", int'(frame_overrun), 1);
        pulse_boundary();
        check_lit("t4_rb2_after", int'(read_bank2), 1);
        $display("frame 3: %0d bits + 5 overrun bits, swapped to bank 2", FB);

        // last strobe lands on the boundary cycle: no swap until the next one
        clear_logs(base);
        cs_low(); send_bits(FB - 1);
        @(posedge CLK_40); #1;
        spi_mosi = 1'b1; spi_sclk = 1'b0;
        repeat (2) @(posedge CLK_40);
        #1 spi_sclk = 1'b1;
        sent_bits.push_back(1'b1);
        repeat (D) @(posedge CLK_40);
        #1 frame_boundary = 1'b1;
        @(posedge CLK_40);
        #1 frame_boundary = 1'b0;
        spi_sclk = 1'b0;
        cs_high();
        check_lit("t5_coincide", coincide_seen, 1);
        check_lit("t5_pending", int'(dut.frame_pending_reg), 1);
        check_lit("t5_no_swap", int'(read_bank2), 1);
        pulse_boundary();
        check_lit("t5_swap_next", int'(read_bank1), 1);
        $display("frame 4: last bit on boundary, swapped one boundary later");

        // random mix of bits, CS gaps and boundaries
        cs_low();
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0: pulse_boundary();
                1: begin
                    @(posedge CLK_40);
                    #1 spi_cs_n = ~spi_cs_n;
                end
                default: send_bit(1'($urandom_range(0, 1)));
            endcase
        end
        cs_high();
        $display("random phase: 250 operations");

        // reset in the middle of a burst discards the partial frame
        cs_low(); send_bits(30);
        apply_reset();
        check_lit("t6_cnt_cleared", int'(dut.bit_cnt_reg), 0);
        check_lit("t6_overrun_cleared", int'(frame_overrun), 0);
        run_startup(SF);
        cs_low(); send_bits(FB - 1); cs_high();
        check_lit("t6_not_pending", int'(dut.frame_pending_reg), 0);
        cs_low(); send_bits(1); cs_high();
        check_lit("t6_pending", int'(dut.frame_pending_reg), 1);
        pulse_boundary();
        check_lit("t6_rb2_after", int'(read_bank2), 1);
        $display("restart: reset at bit 30, fresh %0d-bit frame after startup", FB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_stream_ctrl.md
# frame_stream_ctrl

Upstream control stage of the video pipeline. Brings the asynchronous SPI stream (SCLK/MOSI/CS_N) into the CLK_40 domain and emits the bit strobe and data bit consumed by the dual-bank video memory. Counts bits per frame and runs the ping-pong bank schedule: it selects the read bank, which implicitly makes the other bank the write bank. It also drives the VGA enable and startup-white controls, and swaps banks only on a VGA frame boundary so the displayed frame never tears.

## Interface
Parameters:
- FRAME_BITS, 30000 — bits per frame (200x150 scaled frame); 48 in TEST mode (8x6)
- STARTUP_FRAMES, 60 — VGA frames of solid white shown before playback may begin
- SYNC_STAGES, 2 — synchronizer depth for SPI inputs (>=2)

Ports:
- CLK_40  in  1  system/pixel clock, 40 MHz
- reset  in  1  asynchronous, active-high
- spi_sclk  in  1  SPI clock, asynchronous, ≤ CLK_40/4
- spi_mosi  in  1  SPI data, sampled on SCLK rising
- spi_cs_n  in  1  SPI chip select, active-low
- frame_boundary  in  1  one-cycle pulse at start of VGA vertical sync
- data_clk_rising_edge  out  1  one-cycle strobe per accepted bit
- received_bit  out  1  data bit, valid while strobe is high
- chip_select  out  1  synchronized, active-high CS
- video_data_ready  out  1  write tracker count enable
- read_bank1  out  1  display bank 1, write bank 2
- read_bank2  out  1  display bank 2, write bank 1
- VGA_en  out  1  VGA timing counter enable
- VGA_startup_en  out  1  force white pixels
- frame_overrun  out  1  sticky: bits arrived while a completed frame awaited swap

## Operation
- Sync: sclk, mosi and cs_n each pass through SYNC_STAGES flops. A registered edge detector on synced sclk (0→1) produces a raw strobe. received_bit is the synced mosi registered with the strobe.
- Accept: a raw strobe is accepted only when chip_select=1, state is WAIT_FIRST or PLAY, and frame_pending=0. data_clk_rising_edge is asserted only for accepted strobes.
- Bit counter: width $clog2(FRAME_BITS+1). Increments on each accepted bit. It holds across CS gaps, so a frame may span several CS bursts. On reaching FRAME_BITS it clears to 0 and sets frame_pending.
- Swap: frame_boundary with frame_pending=1 toggles the bank select and clears frame_pending.
- Rejected strobe while frame_pending=1: sets frame_overrun; the bit is dropped, not counted. Only reset clears frame_overrun.
- video_data_ready = chip_select & (state is WAIT_FIRST or PLAY).
- FSM (ctrl_state_t):
  - IDLE: all outputs 0. Goes to STARTUP on the next cycle after reset release.
  - STARTUP: VGA_en=1, VGA_startup_en=1, read_bank1=1. Counts frame_boundary pulses; at STARTUP_FRAMES goes to WAIT_FIRST.
  - WAIT_FIRST: still white, read_bank1=1, bank 2 being written. On the first swap goes to PLAY; VGA_startup_en drops in the same cycle that read_bank2 rises.
  - PLAY: VGA_en=1, VGA_startup_en=0, swaps as above. Terminal until reset.
- Exactly one of read_bank1/read_bank2 is high in every state except IDLE.

## Timing
- Reset values: every output 0, counters 0, state IDLE, frame_pending 0.
- Latency: sclk rising edge at the pin → data_clk_rising_edge high SYNC_STAGES+1 CLK_40 cycles later, for exactly 1 cycle. received_bit has the same latency.
- Completion and swap: frame_pending sets the cycle after the FRAME_BITS-th strobe. A frame_boundary in that same cycle does not swap; the swap occurs at the next boundary. Bank outputs change the cycle after the boundary pulse.
- Reset mid-frame or mid-burst: immediate return to IDLE; the partial frame is discarded.
- CS deassert mid-bit: an edge that was in flight and seen after CS drops is rejected.

## Structure
- video_pkg: ctrl_state_t enum (IDLE, STARTUP, WAIT_FIRST, PLAY), TEST/NORMAL FRAME_BITS constants.
- Sub-module spi_sync: synchronizer chain plus sclk edge detect, outputs raw strobe/bit/cs. The FSM, counters and bank select stay in the top module.

## Test plan
- Reset released, 60 frame_boundary pulses → VGA_en=1 throughout; VGA_startup_en=1 and read_bank1=1; state WAIT_FIRST after the 60th pulse.
- FRAME_BITS=48: 48 SCLK edges with CS low, then one boundary → 48 strobes with mosi values matching in order; read_bank2=1 and VGA_startup_en=0 the cycle after the boundary.
- Same 48-bit frame split as 20 bits, CS high 100 cycles, then 28 bits → one frame_pending, swap at the next boundary.
- 48 bits, then 5 extra bits before the boundary → no strobes for the 5 bits, frame_overrun=1, swap still occurs.
- 48th strobe coincides with frame_boundary → no swap; swap at the following boundary.
- Assert reset mid-burst at bit 30 → all outputs 0 next cycle; after restart the frame count begins from 0.
